// File: rtl/spinner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spinner_pkg
// Purpose  : Shared types, constants and Gray-code step helpers for the
//            spinner quadrature front end.
// Contents : ACC_W_DEFAULT  - default residual accumulator width
//            DELTA_MAX      - largest magnitude published per sample
//            quad_t         - 2-bit {A,B} quadrature state
//            step_t         - signed 2-bit step (-1 / 0 / +1)
//            quad_step()    - decode prev->cur into a step
//            quad_illegal() - true when both phases changed at once
// Revision : 1.0 - initial release
// ============================================================================
package spinner_pkg;

    localparam int ACC_W_DEFAULT = 12;
    localparam int DELTA_MAX     = 127;

    typedef logic [1:0]        quad_t;
    typedef logic signed [1:0] step_t;

    localparam step_t STEP_NONE = 2'sb00;
    localparam step_t STEP_FWD  = 2'sb01;
    localparam step_t STEP_REV  = 2'sb11;

    // Forward order of the Gray sequence is 00 -> 01 -> 11 -> 10 -> 00.
    function automatic step_t quad_step(input quad_t prev, input quad_t cur);
        step_t s;
        case ({prev, cur})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: s = STEP_FWD;
            4'b0100, 4'b1101, 4'b1011, 4'b0010: s = STEP_REV;
            default:                            s = STEP_NONE;
        endcase
        return s;
    endfunction

    function automatic logic quad_illegal(input quad_t prev, input quad_t cur);
        return (prev ^ cur) == 2'b11;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spinner_quad_debounce.sv
`default_nettype none
// ============================================================================
// Module   : quad_debounce
// Purpose  : Two-flop synchroniser plus level debouncer for one encoder phase.
//            A new level is accepted once the synchronised input has
//            disagreed with the accepted level for DEBOUNCE consecutive cycles.
// Ports    : clk   - core clock
//            reset - synchronous, active-high
//            raw   - asynchronous phase input
//            level - debounced, accepted level
// Revision : 1.0 - initial release
// ============================================================================
module quad_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam logic [7:0] C_LAST = 8'(DEBOUNCE - 1);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_level;
    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= 8'd0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= 8'd0;
            end else if (r_cnt == C_LAST) begin
                // This cycle is the DEBOUNCE-th disagreeing sample.
                r_level <= r_sync2;
                r_cnt   <= 8'd0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/spinner_quad.sv
`default_nettype none
// ============================================================================
// Module   : spinner_quad
// Purpose  : Quadrature encoder front end. Debounces A/B, decodes Gray steps
//            into a saturating signed residual, and on each tick publishes a
//            clamped signed 8-bit delta with a toggling new-sample flag.
// Ports    : clk      - core clock
//            reset    - synchronous, active-high
//            quad_a   - encoder phase A (asynchronous)
//            quad_b   - encoder phase B (asynchronous)
//            tick     - single-cycle emission strobe
//            spin_out - [8] sample toggle, [7:0] signed delta
//            glitch   - one-cycle pulse after an illegal A/B transition
// Revision : 1.0 - initial release
// ============================================================================
module spinner_quad
    import spinner_pkg::*;
#(
    parameter int DEBOUNCE = 4,
    parameter bit INVERT   = 1'b0,
    parameter int ACC_W    = ACC_W_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       quad_a,
    input  logic       quad_b,
    input  logic       tick,
    output logic [8:0] spin_out,
    output logic       glitch
);

    localparam int SUM_W = ACC_W + 2;
    localparam logic signed [SUM_W-1:0] C_ACC_MAX = SUM_W'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] C_ACC_MIN = -C_ACC_MAX;
    localparam logic signed [ACC_W-1:0] C_DMAX    = ACC_W'(DELTA_MAX);
    localparam logic signed [ACC_W-1:0] C_DMIN    = -C_DMAX;

    typedef enum logic [0:0] {
        PRIME_WAIT = 1'b0,
        PRIME_DONE = 1'b1
    } prime_state_t;

    logic                    w_a;
    logic                    w_b;
    quad_t                   w_cur;
    prime_state_t            r_state;
    prime_state_t            w_state_next;
    quad_t                   r_prev;
    step_t                   w_step;
    step_t                   w_step_dir;
    logic                    w_illegal;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_acc_next;
    logic signed [7:0]       w_emit;
    logic                    w_emit_en;
    logic signed [SUM_W-1:0] w_sum;
    logic [8:0]              r_spin;
    logic                    r_glitch;

    quad_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_a (
        .clk   (clk),
        .reset (reset),
        .raw   (quad_a),
        .level (w_a)
    );

    quad_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_b (
        .clk   (clk),
        .reset (reset),
        .raw   (quad_b),
        .level (w_b)
    );

    assign w_cur = {w_a, w_b};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= PRIME_WAIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // While unprimed the current levels only become the baseline.
    always_comb begin
        w_state_next = r_state;
        w_step       = STEP_NONE;
        w_illegal    = 1'b0;
        case (r_state)
            PRIME_WAIT: w_state_next = PRIME_DONE;
            PRIME_DONE: begin
                w_step    = quad_step(r_prev, w_cur);
                w_illegal = quad_illegal(r_prev, w_cur);
            end
            default:    w_state_next = PRIME_WAIT;
        endcase
    end

    assign w_step_dir = INVERT ? -w_step : w_step;

    // Emission uses the pre-step residual; clamp keeps -128 out of the stream.
    assign w_emit_en = tick && (r_acc != '0);

    always_comb begin
        w_emit = 8'sd0;
        if (w_emit_en) begin
            if (r_acc > C_DMAX) begin
                w_emit = 8'sd127;
            end else if (r_acc < C_DMIN) begin
                w_emit = -8'sd127;
            end else begin
                w_emit = r_acc[7:0];
            end
        end
    end

    assign w_sum = SUM_W'(r_acc) - SUM_W'(w_emit) + SUM_W'(w_step_dir);

    always_comb begin
        w_acc_next = w_sum[ACC_W-1:0];
        if (w_sum > C_ACC_MAX) begin
            w_acc_next = C_ACC_MAX[ACC_W-1:0];
        end else if (w_sum < C_ACC_MIN) begin
            w_acc_next = C_ACC_MIN[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev   <= 2'b00;
            r_acc    <= '0;
            r_spin   <= 9'h000;
            r_glitch <= 1'b0;
        end else begin
            r_prev   <= w_cur;
            r_acc    <= w_acc_next;
            r_glitch <= w_illegal;
            if (w_emit_en) begin
                r_spin <= {~r_spin[8], w_emit};
            end
        end
    end

    assign spin_out = r_spin;
    assign glitch   = r_glitch;

endmodule
`default_nettype wire

// File: tb/tb_spinner_quad.sv
`default_nettype none
// ============================================================================
// Module   : tb_spinner_quad
// Purpose  : Directed testbench for spinner_quad. A normal and an inverted
//            instance share the same stimulus; a reference model of the
//            encoder path predicts both outputs every cycle, and literal
//            values pin the model at key points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spinner_quad;

    localparam int DEBOUNCE = 4;
    localparam int ACC_W    = 12;
    localparam int ACC_LIM  = (1 << (ACC_W - 1)) - 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       quad_a;
    logic       quad_b;
    logic       tick;
    logic [8:0] spin_out;
    logic       glitch;
    logic [8:0] spin_out_inv;
    logic       glitch_inv;

    always #5 clk = ~clk;

    spinner_quad #(.DEBOUNCE(DEBOUNCE), .INVERT(1'b0), .ACC_W(ACC_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .quad_a   (quad_a),
        .quad_b   (quad_b),
        .tick     (tick),
        .spin_out (spin_out),
        .glitch   (glitch)
    );

    spinner_quad #(.DEBOUNCE(DEBOUNCE), .INVERT(1'b1), .ACC_W(ACC_W)) dut_inv (
        .clk      (clk),
        .reset    (reset),
        .quad_a   (quad_a),
        .quad_b   (quad_b),
        .tick     (tick),
        .spin_out (spin_out_inv),
        .glitch   (glitch_inv)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int glitch_cnt = 0;
    int pos = 2;

    // ---------------- reference model (non-inverted view) ----------------
    bit m_s1 [2];
    bit m_s2 [2];
    bit m_lvl [2];
    int m_run [2];
    bit m_primed;
    int m_prev_pos;
    int m_acc;
    bit m_flag;
    int m_delta;
    bit m_glitch;

    // Position of an {A,B} pair along the forward Gray cycle.
    function automatic int gray_pos(input bit a, input bit b);
        if (!a && !b) return 0;
        if (!a &&  b) return 1;
        if ( a &&  b) return 2;
        return 3;
    endfunction

    always @(posedge clk) begin
        int cur;
        int d;
        int step;
        int emitted;
        bit raw [2];
        raw[0] = quad_a;
        raw[1] = quad_b;
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                m_s1[p] = 1'b0; m_s2[p] = 1'b0; m_lvl[p] = 1'b0; m_run[p] = 0;
            end
            m_primed = 1'b0; m_prev_pos = 0; m_acc = 0;
            m_flag = 1'b0; m_delta = 0; m_glitch = 1'b0;
        end else begin
            cur = gray_pos(m_lvl[0], m_lvl[1]);
            step = 0;
            m_glitch = 1'b0;
            if (!m_primed) begin
                m_primed = 1'b1;
            end else begin
                d = (cur - m_prev_pos + 4) % 4;
                if (d == 1) step = 1;
                else if (d == 3) step = -1;
                m_glitch = (d == 2);
            end
            m_prev_pos = cur;
            emitted = 0;
            if (tick && m_acc != 0) begin
                emitted = (m_acc > 127) ? 127 : (m_acc < -127) ? -127 : m_acc;
                m_flag = ~m_flag;
                m_delta = emitted;
            end
            m_acc = m_acc - emitted + step;
            if (m_acc > ACC_LIM) m_acc = ACC_LIM;
            if (m_acc < -ACC_LIM) m_acc = -ACC_LIM;
            for (int p = 0; p < 2; p++) begin
                if (m_s2[p] != m_lvl[p]) begin
                    m_run[p] = m_run[p] + 1;
                    if (m_run[p] == DEBOUNCE) begin
                        m_lvl[p] = m_s2[p];
                        m_run[p] = 0;
                    end
                end else begin
                    m_run[p] = 0;
                end
                m_s2[p] = m_s1[p];
                m_s1[p] = raw[p];
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        logic [8:0] e_spin;
        logic [8:0] e_inv;
        logic [7:0] dn;
        if (chk_en) begin
            dn = 8'(-m_delta);
            e_spin = {m_flag, 8'(m_delta)};
            e_inv  = {m_flag, dn};
            checks = checks + 4;
            if (spin_out !== e_spin) begin
                errors++;
                $display("FAIL spin_out @%0t: got %h expected %h", $time, spin_out, e_spin);
            end
            if (glitch !== m_glitch) begin
                errors++;
                $display("FAIL glitch @%0t: got %b expected %b", $time, glitch, m_glitch);
            end
            if (spin_out_inv !== e_inv) begin
                errors++;
                $display("FAIL spin_out_inv @%0t: got %h expected %h", $time, spin_out_inv, e_inv);
            end
            if (glitch_inv !== m_glitch) begin
                errors++;
                $display("FAIL glitch_inv @%0t: got %b expected %b", $time, glitch_inv, m_glitch);
            end
        end
        if (glitch === 1'b1) glitch_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_pos(input int p);
        case (p)
            0: begin quad_a = 1'b0; quad_b = 1'b0; end
            1: begin quad_a = 1'b0; quad_b = 1'b1; end
            2: begin quad_a = 1'b1; quad_b = 1'b1; end
            default: begin quad_a = 1'b1; quad_b = 1'b0; end
        endcase
    endtask

    task automatic steps(input int n, input int dir, input int hold);
        for (int i = 0; i < n; i++) begin
            pos = (pos + dir + 4) % 4;
            set_pos(pos);
            cyc(hold);
        end
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(2);
    endtask

    task automatic lit(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1;
        tick  = 1'b0;
        pos   = 2;
        set_pos(pos);
        cyc(5);
        chk_en = 1'b1;
        lit("reset_spin", spin_out, 9'h000);

        // Release with 11 held: baseline is 00, so no step ever lands.
        reset = 1'b0;
        cyc(20);
        do_tick();
        lit("prime_no_toggle", spin_out, 9'h000);

        steps(20, 1, 10);
        cyc(10);
        do_tick();
        lit("fwd20", spin_out, 9'h114);
        lit("fwd20_inv", spin_out_inv, 9'h1EC);
        do_tick();
        lit("fwd20_idle_tick", spin_out, 9'h114);

        steps(300, -1, 7);
        cyc(10);
        do_tick();
        lit("rev_tick1", spin_out, 9'h081);
        do_tick();
        lit("rev_tick2", spin_out, 9'h181);
        do_tick();
        lit("rev_tick3", spin_out, 9'h0D2);
        lit("rev_tick3_inv", spin_out_inv, 9'h02E);
        do_tick();
        lit("rev_tick4_idle", spin_out, 9'h0D2);

        // Short pulse on A, then both phases flip together.
        quad_a = ~quad_a;
        cyc(3);
        quad_a = ~quad_a;
        cyc(15);
        glitch_cnt = 0;
        pos = 0;
        set_pos(pos);
        cyc(15);
        lit("glitch_once", 9'(glitch_cnt), 9'd1);
        do_tick();
        lit("after_glitch_idle", spin_out, 9'h0D2);

        // acc=+5, then tick aligned with the decode cycle of a further step.
        steps(5, 1, 10);
        cyc(10);
        pos = (pos + 1) % 4;
        set_pos(pos);
        cyc(6);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(10);
        lit("coincident_emit", spin_out, 9'h105);
        do_tick();
        lit("residual_emit", spin_out, 9'h001);
        lit("residual_emit_inv", spin_out_inv, 9'h0FF);

        steps(8, 1, 10);
        cyc(10);
        do_tick();
        lit("fwd8", spin_out, 9'h108);
        lit("fwd8_inv", spin_out_inv, 9'h1F8);

        // Leave residual pending, then reset mid-stream.
        steps(2, 1, 10);
        reset = 1'b1;
        cyc(3);
        lit("midreset_spin", spin_out, 9'h000);
        lit("midreset_spin_inv", spin_out_inv, 9'h000);
        reset = 1'b0;
        cyc(20);
        do_tick();
        lit("post_reset_idle", spin_out, 9'h000);
        lit("post_reset_idle_inv", spin_out_inv, 9'h000);

        cyc(5);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
